// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
//   OP_*    : 4-bit opcode encoding, identical to the combinational datapath ALU
//   state_t : control FSM states of alu_seq
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_MUL = 4'b0111;
  localparam logic [3:0] OP_DIV = 4'b0011;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply / restoring divide engine, one bit per cycle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load operands and begin WIDTH iterations
//   is_div     : 1 = divide a / b, 0 = multiply a * b (sampled on start)
//   a, b       : operands (sampled on start only)
//   done       : high during the final iteration; result/ovf are valid then
//   result     : low product word or quotient
//   ovf        : product high word non-zero, or divide by zero
module alu_muldiv_iter #(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  // acc high half: partial product (MUL) or partial remainder (DIV).
  // acc low half : multiplier shifting out (MUL) or dividend shifting out
  //                while quotient bits shift in (DIV).
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   sreg;   // multiplicand or divisor
  logic [CNT_W-1:0]   cnt;
  logic               div_q;
  logic               run;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     div_diff;

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, sreg} : '0);
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff = rem_sh - {1'b0, sreg};
    if (div_q) begin
      // Negative trial difference: restore (keep shifted remainder), quotient bit 0.
      acc_nxt = div_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Result is taken from the final step's next value so the top can finish
  // in the same cycle the counter reaches 1.
  assign done   = run && (cnt == CNT_W'(1));
  assign result = acc_nxt[WIDTH-1:0];
  assign ovf    = div_q ? (sreg == '0) : (|acc_nxt[2*WIDTH-1:WIDTH]);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      sreg  <= '0;
      cnt   <= '0;
      div_q <= 1'b0;
      run   <= 1'b0;
    end else if (start) begin
      acc   <= {{WIDTH{1'b0}}, (is_div ? a : b)};
      sreg  <= is_div ? b : a;
      cnt   <= CNT_W'(WIDTH);
      div_q <= is_div;
      run   <= 1'b1;
    end else if (run) begin
      acc <= acc_nxt;
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes and iterative MUL/DIV.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (ready only in IDLE)
//   op, a, b             : opcode and operands, captured on accept
//   out_valid / out_ready: result handshake
//   result, zero, ovf    : registered result, result==0, overflow / div-by-zero
//   illegal              : opcode outside the supported encoding
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           state, state_nxt;
  logic             load;
  logic             md_start;
  logic [WIDTH-1:0] res_nxt;
  logic             ovf_nxt;
  logic             ill_nxt;

  logic             md_done;
  logic [WIDTH-1:0] md_result;
  logic             md_ovf;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             add_ovf;
  logic             sub_ovf;

  assign sum     = a + b;
  assign diff    = a - b;
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  // Gated by rst_n so the upstream stage never sees ready while held in reset.
  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == DONE);

  alu_muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .is_div (op == OP_DIV),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .result (md_result),
    .ovf    (md_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    md_start  = 1'b0;
    res_nxt   = '0;
    ovf_nxt   = 1'b0;
    ill_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          case (op)
            OP_AND: begin load = 1'b1; res_nxt = a & b; state_nxt = DONE; end
            OP_OR:  begin load = 1'b1; res_nxt = a | b; state_nxt = DONE; end
            OP_ADD: begin
              load = 1'b1; res_nxt = sum;  ovf_nxt = add_ovf; state_nxt = DONE;
            end
            OP_SUB: begin
              load = 1'b1; res_nxt = diff; ovf_nxt = sub_ovf; state_nxt = DONE;
            end
            OP_MUL: begin md_start = 1'b1; state_nxt = MUL; end
            OP_DIV: begin md_start = 1'b1; state_nxt = DIV; end
            default: begin load = 1'b1; ill_nxt = 1'b1; state_nxt = DONE; end
          endcase
        end
      end
      MUL, DIV: begin
        if (md_done) begin
          load      = 1'b1;
          res_nxt   = md_result;
          ovf_nxt   = md_ovf;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output registers only load on entry to DONE, so they hold through the
  // output stall and keep their value while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result  <= '0;
      zero    <= 1'b0;
      ovf     <= 1'b0;
      illegal <= 1'b0;
    end else if (load) begin
      result  <= res_nxt;
      zero    <= (res_nxt == '0);
      ovf     <= ovf_nxt;
      illegal <= ill_nxt;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  import alu_pkg::*;

  typedef struct {
    logic [63:0] res;
    logic        zero;
    logic        ovf;
    logic        ill;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sel = 1'b0;          // 0: drive/observe 8-bit DUT, 1: 64-bit DUT
  logic        drv_valid = 1'b0;
  logic        drv_ready = 1'b0;
  logic [3:0]  drv_op = 4'd0;
  logic [63:0] drv_a = '0;
  logic [63:0] drv_b = '0;

  logic        rdy8, v8, z8, o8, i8;
  logic [7:0]  res8;
  logic        rdy64, v64, z64, o64, i64;
  logic [63:0] res64;

  logic        obs_rdy, obs_v, obs_z, obs_o, obs_i;
  logic [63:0] obs_res;

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (drv_valid & ~sel),
    .in_ready  (rdy8),
    .op        (drv_op),
    .a         (drv_a[7:0]),
    .b         (drv_b[7:0]),
    .out_valid (v8),
    .out_ready (drv_ready),
    .result    (res8),
    .zero      (z8),
    .ovf       (o8),
    .illegal   (i8)
  );

  alu_seq #(.WIDTH(64)) dut64 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (drv_valid & sel),
    .in_ready  (rdy64),
    .op        (drv_op),
    .a         (drv_a),
    .b         (drv_b),
    .out_valid (v64),
    .out_ready (drv_ready),
    .result    (res64),
    .zero      (z64),
    .ovf       (o64),
    .illegal   (i64)
  );

  assign obs_rdy = sel ? rdy64 : rdy8;
  assign obs_v   = sel ? v64   : v8;
  assign obs_z   = sel ? z64   : z8;
  assign obs_o   = sel ? o64   : o8;
  assign obs_i   = sel ? i64   : i8;
  assign obs_res = sel ? res64 : {56'd0, res8};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model built from wide integer arithmetic.
  function automatic exp_t model(input int w, input logic [3:0] o,
                                 input logic [63:0] aa_in, input logic [63:0] bb_in);
    exp_t e;
    logic [63:0] mask, aa, bb;
    logic signed [127:0] sa, sb_s, t, smax, smin;
    logic [127:0] p;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    aa = aa_in & mask;
    bb = bb_in & mask;
    sa = $signed({64'd0, aa});
    sb_s = $signed({64'd0, bb});
    if (aa[w-1]) sa = sa - (128'sd1 <<< w);
    if (bb[w-1]) sb_s = sb_s - (128'sd1 <<< w);
    smax = (128'sd1 <<< (w - 1)) - 128'sd1;
    smin = -(128'sd1 <<< (w - 1));
    e.res = '0; e.ovf = 1'b0; e.ill = 1'b0; e.lat = 1;
    case (o)
      OP_AND: e.res = aa & bb;
      OP_OR:  e.res = aa | bb;
      OP_ADD: begin t = sa + sb_s; e.res = (aa + bb) & mask; e.ovf = (t > smax) || (t < smin); end
      OP_SUB: begin t = sa - sb_s; e.res = (aa - bb) & mask; e.ovf = (t > smax) || (t < smin); end
      OP_MUL: begin
        p = {64'd0, aa} * {64'd0, bb};
        e.res = p[63:0] & mask;
        e.ovf = (p >> w) != 128'd0;
        e.lat = w + 1;
      end
      OP_DIV: begin
        if (bb == 64'd0) begin e.res = mask; e.ovf = 1'b1; end
        else e.res = aa / bb;
        e.lat = w + 1;
      end
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.res == 64'd0);
    return e;
  endfunction

  // One transaction: drive, push expectation, wait for out_valid (bounded),
  // pop and compare, stall out_ready for 'hold' cycles, then consume.
  task automatic run_op(input logic s64, input logic [3:0] o,
                        input logic [63:0] aa, input logic [63:0] bb, input int hold);
    exp_t e, got_e;
    int cyc;
    sel = s64;
    @(negedge clk);
    check("in_ready_idle", {63'd0, obs_rdy}, 64'd1);
    drv_op = o; drv_a = aa; drv_b = bb; drv_valid = 1'b1; drv_ready = 1'b0;
    sb.push_back(model(s64 ? 64 : 8, o, aa, bb));
    @(negedge clk);
    // Busy-time noise: must be ignored and must not disturb the op in flight.
    drv_op = OP_ADD; drv_a = {$urandom, $urandom}; drv_b = {$urandom, $urandom};
    cyc = 1;
    while (!obs_v && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!obs_v) begin
      check("timeout_out_valid", 64'd0, 64'd1);
      drv_valid = 1'b0;
      void'(sb.pop_front());
      return;
    end
    got_e = sb.pop_front();
    e = got_e;
    check("latency", 64'(cyc), 64'(e.lat));
    check("result",  obs_res, e.res);
    check("zero",    {63'd0, obs_z}, {63'd0, e.zero});
    check("ovf",     {63'd0, obs_o}, {63'd0, e.ovf});
    check("illegal", {63'd0, obs_i}, {63'd0, e.ill});
    check("in_ready_busy", {63'd0, obs_rdy}, 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid",   {63'd0, obs_v}, 64'd1);
      check("hold_result",  obs_res, e.res);
      check("hold_zero",    {63'd0, obs_z}, {63'd0, e.zero});
      check("hold_ovf",     {63'd0, obs_o}, {63'd0, e.ovf});
      check("hold_ready",   {63'd0, obs_rdy}, 64'd0);
    end
    drv_ready = 1'b1;
    drv_valid = 1'b0;
    @(negedge clk);
    drv_ready = 1'b0;
    check("valid_drop",    {63'd0, obs_v}, 64'd0);
    check("ready_return",  {63'd0, obs_rdy}, 64'd1);
    check("idle_result",   obs_res, e.res);
  endtask

  initial begin
    logic [3:0] r_op;
    int seen;

    // Reset state.
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready8",  {63'd0, rdy8}, 64'd0);
    check("rst_in_ready64", {63'd0, rdy64}, 64'd0);
    check("rst_valid8",     {63'd0, v8}, 64'd0);
    check("rst_result8",    {56'd0, res8}, 64'd0);
    check("rst_flags8",     {61'd0, z8, o8, i8}, 64'd0);
    check("rst_result64",   res64, 64'd0);
    check("rst_flags64",    {60'd0, v64, z64, o64, i64}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed 8-bit cases.
    run_op(1'b0, OP_ADD, 64'h7F, 64'h01, 0);
    run_op(1'b0, OP_SUB, 64'h05, 64'h05, 3);
    run_op(1'b0, OP_MUL, 64'h10, 64'h20, 1);
    run_op(1'b0, OP_MUL, 64'h0F, 64'h03, 0);
    run_op(1'b0, OP_DIV, 64'hC8, 64'h07, 0);
    run_op(1'b0, OP_DIV, 64'h10, 64'h00, 2);
    run_op(1'b0, OP_SUB, 64'h80, 64'h01, 0);
    run_op(1'b0, OP_MUL, 64'hFF, 64'hFF, 0);
    run_op(1'b0, OP_DIV, 64'h05, 64'h09, 0);

    // Random 8-bit mix, illegal encodings included.
    for (int k = 0; k < 20; k++) begin
      r_op = 4'($urandom_range(0, 15));
      run_op(1'b0, r_op, 64'($urandom_range(0, 255)), 64'($urandom_range(0, 255)),
             $urandom_range(0, 2));
    end

    // 64-bit cases.
    run_op(1'b1, 4'b0101, {$urandom, $urandom}, {$urandom, $urandom}, 0);
    run_op(1'b1, OP_AND, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1);
    run_op(1'b1, OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0);
    run_op(1'b1, OP_MUL, {$urandom, $urandom}, 64'($urandom), 0);
    run_op(1'b1, OP_MUL, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 0);
    run_op(1'b1, OP_DIV, {$urandom, $urandom}, 64'($urandom_range(1, 1000)), 0);
    run_op(1'b1, OP_DIV, 64'h1234, 64'd0, 0);

    // Reset four cycles into a DIV on the 8-bit block.
    sel = 1'b0;
    @(negedge clk);
    drv_op = OP_DIV; drv_a = 64'hC8; drv_b = 64'h07; drv_valid = 1'b1;
    @(negedge clk);
    drv_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready_low", {63'd0, rdy8}, 64'd0);
    check("abort_valid",  {63'd0, v8}, 64'd0);
    check("abort_result", {56'd0, res8}, 64'd0);
    check("abort_flags",  {61'd0, z8, o8, i8}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", {63'd0, rdy8}, 64'd1);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (v8) seen++;
    end
    check("abort_no_valid", 64'(seen), 64'd0);
    check("abort_result_idle", {56'd0, res8}, 64'd0);
    run_op(1'b0, OP_ADD, 64'd2, 64'd3, 0);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, sequential successor to the combinational 64-bit datapath ALU.
- Same opcode encoding, with a WIDTH parameter, a valid/ready handshake on both sides, and iterative multi-cycle multiply and divide.
- Defined per-op overflow semantics and an illegal-opcode flag.
- Sits between the decode/register-read stage and writeback; stalls upstream via in_ready while a multi-cycle op runs.

Parameters:
- WIDTH, 64, operand/result width in bits (min 4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand/op presented
- in_ready  out  1  block can accept; high only in IDLE
- op  in  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 MUL, 0011 DIV
- a, b  in  WIDTH  operands
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  op result
- zero  out  1  result == 0
- ovf  out  1  overflow / divide-by-zero
- illegal  out  1  op not in the encoding list

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; result=0, zero=0, ovf=0, illegal=0, out_valid=0; counter and working registers cleared.
  - in_ready=0 while rst_n low, 1 the first cycle after release.
- Accept: in_valid && in_ready on a rising edge; a, b and op are captured. in_ready=0 from the next cycle until the result is consumed.
- States: IDLE, MUL, DIV, DONE.
  - IDLE -> DONE for AND/OR/ADD/SUB/illegal; out_valid=1 one cycle after accept (latency 1).
  - IDLE -> MUL / DIV; counter loads WIDTH and decrements each cycle.
    - At counter==1 -> DONE, so out_valid rises WIDTH+1 cycles after accept.
  - DONE: result, zero, ovf and illegal are held stable while out_valid=1 and out_ready=0.
    - out_valid && out_ready -> IDLE; out_valid=0 the next cycle.
  - No back-to-back accept in the cycle of output handshake; throughput is at most one op per 2 cycles.
- Arithmetic:
  - ADD/SUB: two's complement, result mod 2^WIDTH. ovf = signed overflow (operand signs equal, and for SUB after b inversion, result sign differs).
  - MUL: unsigned shift-add, one partial product per cycle into a 2*WIDTH accumulator. result = low WIDTH bits; ovf = |high WIDTH bits.
  - DIV: unsigned restoring, one quotient bit per cycle. result = quotient; remainder discarded.
    - b==0: still takes WIDTH+1 cycles; result = all ones, ovf=1.
  - AND/OR: bitwise; ovf=0.
  - Illegal op: result=0, zero=1, ovf=0, illegal=1, latency 1.
- zero: registered together with result; always equals (result==0) whenever out_valid=1.
- Outputs are unchanged outside DONE, except cleared by reset.
- in_valid while busy is ignored; the operands are not latched.
- Reset mid-MUL/DIV: operation abandoned, no out_valid, block returns to IDLE.
- Operands a, b may change after accept without affecting the op in flight.

Decomposition:
- Package alu_pkg:
  - op localparams: OP_AND, OP_OR, OP_ADD, OP_SUB, OP_MUL, OP_DIV
  - state enum: IDLE, MUL, DIV, DONE
- One natural sub-module: alu_muldiv_iter. It holds the shared shift register, accumulator and counter for MUL/DIV, with start, done, ovf and result ports. The top holds the FSM, single-cycle ops and handshake.

Test Plan:
- WIDTH=8, ADD a=0x7F b=0x01 -> out_valid 1 cycle after accept; result=0x80, ovf=1, zero=0.
- WIDTH=8, SUB a=0x05 b=0x05 -> result=0x00, zero=1, ovf=0; out_ready held low 3 cycles -> outputs stable, in_ready=0 throughout.
- WIDTH=8, MUL a=0x10 b=0x20 -> out_valid exactly 9 cycles after accept; result=0x00, ovf=1, zero=1. Then MUL 0x0F*0x03 -> 0x2D, ovf=0.
- WIDTH=8, DIV a=0xC8 b=0x07 -> result=0x1C after 9 cycles. DIV a=0x10 b=0x00 -> result=0xFF, ovf=1.
- WIDTH=64, op=0101 -> result=0, illegal=1, zero=1 after 1 cycle. AND 0xF0F0...F0 with 0xFF00...00 -> 0xF000...00 (alternating F0/00 bytes).
- WIDTH=8, rst_n pulsed low 4 cycles into a DIV -> out_valid never asserts, all outputs 0, in_ready=1 the cycle after release. A following ADD 2+3 -> 5.
